// File: rtl/zero_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zero_pkg
// Purpose  : Shared types and helpers for the zero/condition detector.
//            cond_mode_t : branch condition select (EQZ/NEZ/LTZ/GEZ)
//            LZC_W(w)    : bits needed to hold a leading-zero count 0..w
// Revision : 1.0 - initial release
// ============================================================================
package zero_pkg;

  typedef enum logic [1:0] {
    EQZ = 2'b00,
    NEZ = 2'b01,
    LTZ = 2'b10,
    GEZ = 2'b11
  } cond_mode_t;

  function automatic int LZC_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zero_chunk.sv
`default_nettype none
// ============================================================================
// Module   : zero_chunk
// Purpose  : Combinational zero flag for one CHUNK-wide slice of the operand,
//            plus its MSB-first leading-zero count when ZERO_DETECT_LZC_EN
//            is defined.
// Ports    : i_bits  [0:CHUNK-1]       slice, index 0 is the most significant
//            o_zero                    slice is all-zero
//            o_lzc   [LZC_W(CHUNK)-1:0] leading zeros 0..CHUNK (macro only)
// Macro    : ZERO_DETECT_LZC_EN
// Revision : 1.0 - initial release
// ============================================================================
module zero_chunk
  import zero_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [0:CHUNK-1]         i_bits,
  output logic                     o_zero
`ifdef ZERO_DETECT_LZC_EN
  ,
  output logic [LZC_W(CHUNK)-1:0]  o_lzc
`endif
);

  assign o_zero = ~|i_bits;

`ifdef ZERO_DETECT_LZC_EN
  localparam int c_LW = LZC_W(CHUNK);

  // Scan from the least significant end so the last hit is the first set bit.
  always_comb begin
    o_lzc = c_LW'(CHUNK);
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (i_bits[i]) o_lzc = c_LW'(i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/zero_detect_pipe.sv
`default_nettype none
// ============================================================================
// Module   : zero_detect_pipe
// Purpose  : Two-stage pipelined zero/condition detector. Stage 1 registers
//            per-chunk zero flags, sign, mode and valid; stage 2 reduces the
//            flags and selects the branch condition. Latency 2, throughput 1.
// Ports    : clk, rst_n (async, active-low)
//            in_valid, in_data [0:WIDTH-1] (bit 0 = MSB/sign), in_mode [1:0]
//            stall (hold both stages), flush (kill in-flight entries)
//            out_valid, out_zero, out_cond
//            out_lzc [LZC_W(WIDTH)-1:0] (only with ZERO_DETECT_LZC_EN)
// Macro    : ZERO_DETECT_LZC_EN adds the leading-zero count output
// Revision : 1.0 - initial release
// ============================================================================
module zero_detect_pipe
  import zero_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8    // WIDTH must be a multiple of CHUNK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [0:WIDTH-1]         in_data,
  input  logic [1:0]               in_mode,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic                     out_zero,
  output logic                     out_cond
`ifdef ZERO_DETECT_LZC_EN
  ,
  output logic [LZC_W(WIDTH)-1:0]  out_lzc
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;

  logic [NCHUNK-1:0] w_cz;
  logic [NCHUNK-1:0] r_cz;
  logic              r_sign;
  cond_mode_t        r_mode;
  logic              r_v1;

`ifdef ZERO_DETECT_LZC_EN
  localparam int c_CLW = LZC_W(CHUNK);
  localparam int c_LZW = LZC_W(WIDTH);
  logic [c_CLW-1:0] w_cl [NCHUNK];
  logic [c_CLW-1:0] r_cl [NCHUNK];
  logic [c_LZW-1:0] w_lzc;
`endif

  // Chunk k covers in_data[k*CHUNK .. k*CHUNK+CHUNK-1]; chunk 0 holds the MSB.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    zero_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .i_bits (in_data[k*CHUNK +: CHUNK]),
      .o_zero (w_cz[k])
`ifdef ZERO_DETECT_LZC_EN
      ,
      .o_lzc  (w_cl[k])
`endif
    );
  end

  // ---------------- Stage 1 ----------------
  // Flush outranks stall for the valid bit; data simply follows stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_cz   <= '0;
      r_sign <= 1'b0;
      r_mode <= EQZ;
    end else begin
      if (flush)       r_v1 <= 1'b0;
      else if (!stall) r_v1 <= in_valid;
      if (!stall) begin
        r_cz   <= w_cz;
        r_sign <= in_data[0];
        r_mode <= cond_mode_t'(in_mode);
      end
    end
  end

`ifdef ZERO_DETECT_LZC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCHUNK; k++) r_cl[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < NCHUNK; k++) r_cl[k] <= w_cl[k];
    end
  end
`endif

  // ---------------- Stage 2 ----------------
  logic w_zero;
  logic w_cond;

  assign w_zero = &r_cz;

  always_comb begin
    w_cond = w_zero;
    case (r_mode)
      EQZ: w_cond = w_zero;
      NEZ: w_cond = ~w_zero;
      LTZ: w_cond = r_sign;
      GEZ: w_cond = ~r_sign;
      default: w_cond = w_zero;
    endcase
  end

`ifdef ZERO_DETECT_LZC_EN
  // First non-zero chunk decides; walking upward lets the lowest index win.
  always_comb begin
    w_lzc = c_LZW'(WIDTH);
    for (int j = NCHUNK - 1; j >= 0; j--) begin
      if (!r_cz[j]) w_lzc = c_LZW'(j * CHUNK) + c_LZW'(r_cl[j]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_cond  <= 1'b0;
`ifdef ZERO_DETECT_LZC_EN
      out_lzc   <= '0;
`endif
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (!stall) out_valid <= r_v1;
      if (!stall) begin
        out_zero <= w_zero;
        out_cond <= w_cond;
`ifdef ZERO_DETECT_LZC_EN
        out_lzc  <= w_lzc;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zero_detect_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_zero_detect_pipe
// Purpose  : Self-checking bench for zero_detect_pipe in three configurations
//            (32/8, 5/5, 64/16) driven in lock-step, compared against an
//            operand-level reference pipeline.
// Macro    : ZERO_DETECT_LZC_EN enables leading-zero count checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_zero_detect_pipe;
  import zero_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic        stall;
  logic        flush;
  logic [31:0] d0;
  logic [4:0]  d1;
  logic [63:0] d2;
  logic [2:0]  ov, oz, oc;
  logic [5:0]  ol0;
  logic [2:0]  ol1;
  logic [6:0]  ol2;

  int n_err = 0;
  int n_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zero_detect_pipe #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(d0), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[0]), .out_zero(oz[0]), .out_cond(oc[0])
`ifdef ZERO_DETECT_LZC_EN
    , .out_lzc(ol0)
`endif
  );
  zero_detect_pipe #(.WIDTH(5), .CHUNK(5)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(d1), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[1]), .out_zero(oz[1]), .out_cond(oc[1])
`ifdef ZERO_DETECT_LZC_EN
    , .out_lzc(ol1)
`endif
  );
  zero_detect_pipe #(.WIDTH(64), .CHUNK(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(d2), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[2]), .out_zero(oz[2]), .out_cond(oc[2])
`ifdef ZERO_DETECT_LZC_EN
    , .out_lzc(ol2)
`endif
  );

`ifndef ZERO_DETECT_LZC_EN
  initial begin ol0 = '0; ol1 = '0; ol2 = '0; end
`endif

  // ---------------- reference model ----------------
  int          wd [3];
  logic        mv1, mv2;
  logic [63:0] s1d [3];
  logic [63:0] s2d [3];
  logic [1:0]  s1m, s2m;

  function automatic logic ref_zero(input logic [63:0] d, input int w);
    logic z;
    z = 1'b1;
    for (int b = 0; b < w; b++) if (d[b]) z = 1'b0;
    return z;
  endfunction

  function automatic logic ref_cond(input logic [63:0] d, input logic [1:0] m, input int w);
    case (m)
      2'd0:    return ref_zero(d, w);
      2'd1:    return !ref_zero(d, w);
      2'd2:    return d[w-1];
      default: return !d[w-1];
    endcase
  endfunction

  function automatic int ref_lzc(input logic [63:0] d, input int w);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    for (int b = w - 1; b >= 0; b--) begin
      if (d[b]) seen = 1'b1;
      else if (!seen) n++;
    end
    return n;
  endfunction

  function automatic logic [63:0] obs_lzc(input int i);
    case (i)
      0:       return 64'(ol0);
      1:       return 64'(ol1);
      default: return 64'(ol2);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (flush) begin
      mv1 = 1'b0;
      mv2 = 1'b0;
    end else if (!stall) begin
      mv2 = mv1;
      s2m = s1m;
      for (int i = 0; i < 3; i++) s2d[i] = s1d[i];
      mv1 = in_valid;
      s1m = in_mode;
      s1d[0] = 64'(d0);
      s1d[1] = 64'(d1);
      s1d[2] = d2;
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid[%0d]", i), 64'(ov[i]), 64'(mv2));
      if (mv2) begin
        chk($sformatf("zero[%0d]", i), 64'(oz[i]), 64'(ref_zero(s2d[i], wd[i])));
        chk($sformatf("cond[%0d]", i), 64'(oc[i]), 64'(ref_cond(s2d[i], s2m, wd[i])));
`ifdef ZERO_DETECT_LZC_EN
        chk($sformatf("lzc[%0d]", i), obs_lzc(i), 64'(ref_lzc(s2d[i], wd[i])));
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] val);
    in_valid = v;
    in_mode  = m;
    d0       = val;
    d1       = val[31:27];
    d2       = {val, val};
  endtask

  // Directed stream: operand, mode, expected cond/zero/lzc on the 32-bit unit
  logic [31:0] tv [5];
  logic [1:0]  tm [5];
  logic        tc [5];
  logic        tz [5];
  int          tl [5];

  initial begin
    wd[0] = 32; wd[1] = 5; wd[2] = 64;
    tv[0] = 32'h00000000; tm[0] = EQZ; tc[0] = 1'b1; tz[0] = 1'b1; tl[0] = 32;
    tv[1] = 32'h00000001; tm[1] = EQZ; tc[1] = 1'b0; tz[1] = 1'b0; tl[1] = 31;
    tv[2] = 32'h80000000; tm[2] = LTZ; tc[2] = 1'b1; tz[2] = 1'b0; tl[2] = 0;
    tv[3] = 32'h7FFFFFFF; tm[3] = GEZ; tc[3] = 1'b1; tz[3] = 1'b0; tl[3] = 1;
    tv[4] = 32'h00800000; tm[4] = NEZ; tc[4] = 1'b1; tz[4] = 1'b0; tl[4] = 8;

    mv1 = 1'b0; mv2 = 1'b0; s1m = '0; s2m = '0;
    for (int i = 0; i < 3; i++) begin s1d[i] = '0; s2d[i] = '0; end

    // Reset state
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, EQZ, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_zero[%0d]", i),  64'(oz[i]), 64'd0);
      chk($sformatf("rst_cond[%0d]", i),  64'(oc[i]), 64'd0);
      chk($sformatf("rst_lzc[%0d]", i),   obs_lzc(i), 64'd0);
    end
    rst_n = 1'b1;
    step();

    // Back-to-back stream, latency 2
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, tm[i], tv[i]);
      else       drive(1'b0, EQZ, 32'h0);
      step();
      if (i >= 1 && i <= 5) begin
        chk($sformatf("stream_valid%0d", i-1), 64'(ov[0]), 64'd1);
        chk($sformatf("stream_cond%0d", i-1),  64'(oc[0]), 64'(tc[i-1]));
        chk($sformatf("stream_zero%0d", i-1),  64'(oz[0]), 64'(tz[i-1]));
`ifdef ZERO_DETECT_LZC_EN
        chk($sformatf("stream_lzc%0d", i-1),   obs_lzc(0), 64'(tl[i-1]));
`endif
      end
    end

    // Stall while 0x00010000 NEZ sits in stage 1
    drive(1'b1, EQZ, 32'h0);
    step();
    drive(1'b1, NEZ, 32'h00010000);
    step();
    stall = 1'b1;
    drive(1'b1, GEZ, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold_valid%0d", i), 64'(ov[0]), 64'd1);
      chk($sformatf("stall_hold_zero%0d", i),  64'(oz[0]), 64'd1);
      chk($sformatf("stall_hold_cond%0d", i),  64'(oc[0]), 64'd1);
    end
    stall = 1'b0;
    drive(1'b0, EQZ, 32'h0);
    step();
    chk("stall_emerge_valid", 64'(ov[0]), 64'd1);
    chk("stall_emerge_zero",  64'(oz[0]), 64'd0);
    chk("stall_emerge_cond",  64'(oc[0]), 64'd1);
    step();
    chk("stall_once", 64'(ov[0]), 64'd0);

    // Flush alone, then flush together with stall
    for (int rep = 0; rep < 2; rep++) begin
      drive(1'b1, EQZ, 32'h0);
      step();
      drive(1'b1, NEZ, 32'h1);
      step();
      chk($sformatf("flush%0d_inflight", rep), 64'(ov[0]), 64'd1);
      flush = 1'b1;
      stall = (rep == 1);
      drive(1'b1, LTZ, 32'h80000000);
      step();
      chk($sformatf("flush%0d_c1", rep), 64'(ov[0]), 64'd0);
      flush = 1'b0;
      stall = 1'b0;
      drive(1'b0, EQZ, 32'h0);
      step();
      chk($sformatf("flush%0d_c2", rep), 64'(ov[0]), 64'd0);
    end

    // Asynchronous reset with both stages valid
    drive(1'b1, EQZ, 32'h0);
    step();
    drive(1'b1, LTZ, 32'hF0000000);
    step();
    drive(1'b1, NEZ, 32'h5);
    step();
    chk("arst_pre_valid", 64'(ov[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_valid[%0d]", i), 64'(ov[i]), 64'd0);
      chk($sformatf("arst_zero[%0d]", i),  64'(oz[i]), 64'd0);
      chk($sformatf("arst_cond[%0d]", i),  64'(oc[i]), 64'd0);
    end
    drive(1'b0, EQZ, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mv1 = 1'b0;
    mv2 = 1'b0;
    repeat (3) step();

    // Randomized traffic against the reference model, all configurations
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_mode  = 2'($urandom_range(0, 3));
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 5);
      d0 = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
      d1 = ($urandom_range(0, 5) == 0) ? 5'h0  : 5'($urandom);
      d2 = ($urandom_range(0, 5) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
      step();
    end
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, EQZ, 32'h0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
